// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   reqN_valid/ready/op/a/b (N=0,1)    request handshake and operands
//   rspN_valid/data/err   (N=0,1)      one-cycle result pulse, result, illegal-op flag
//   alu_op/alu_a/alu_b                 registered drive into the external ALU
//   alu_out                            combinational ALU result
module alu_arbiter #(
    parameter int WIDTH  = 32,
    parameter int OPW    = 4,
    parameter int MAX_OP = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             rsp0_valid,
    output logic [WIDTH-1:0] rsp0_data,
    output logic             rsp0_err,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp1_data,
    output logic             rsp1_err,
    output logic [OPW-1:0]   alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out
);
    localparam logic [OPW-1:0] LAST_OP = OPW'(MAX_OP);

    logic             ptr;
    logic             grant0, grant1, illegal;
    logic             s1_valid, s1_id;
    logic             s2_valid, s2_id, s2_err;
    logic [WIDTH-1:0] s2_data;

    // ptr names the requester that wins a tie; gating with rst_n keeps ready low in reset
    always_comb begin
        grant0  = rst_n & req0_valid & (~req1_valid | ~ptr);
        grant1  = rst_n & req1_valid & (~req0_valid | ptr);
        illegal = alu_op > LAST_OP;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp0_valid = s2_valid & ~s2_id;
    assign rsp1_valid = s2_valid & s2_id;
    assign rsp0_data  = s2_data;
    assign rsp1_data  = s2_data;
    assign rsp0_err   = s2_err;
    assign rsp1_err   = s2_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr      <= 1'b0;
            s1_valid <= 1'b0;
            s1_id    <= 1'b0;
            alu_op   <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            s2_valid <= 1'b0;
            s2_id    <= 1'b0;
            s2_data  <= '0;
            s2_err   <= 1'b0;
        end else begin
            s1_valid <= grant0 | grant1;
            // ALU drive only changes on accept so an idle ALU sees stable inputs
            if (grant0 | grant1) begin
                ptr    <= grant0;
                s1_id  <= grant1;
                alu_op <= grant1 ? req1_op : req0_op;
                alu_a  <= grant1 ? req1_a : req0_a;
                alu_b  <= grant1 ? req1_b : req0_b;
            end
            s2_valid <= s1_valid;
            s2_id    <= s1_id;
            s2_err   <= illegal;
            s2_data  <= illegal ? '0 : alu_out;
        end
    end
endmodule
